uart_link_ctrl: RTL and testbench

UART_LINK_CTRL -- requirements
Module: uart_link_ctrl

---
 rtl/uart_ctrl_pkg.sv | 21 ++
 rtl/uart_link_ctrl_if.sv | 43 ++++
 rtl/uart_frame_timer.sv | 39 +++
 rtl/uart_link_ctrl.sv | 147 ++++++++++++++
 tb/tb_uart_link_ctrl.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared types and sizing helpers for the UART link controller and its frame timer.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_SEND = 2'd1,
        TX_WAIT = 2'd2
    } tx_state_e;

    localparam int unsigned FRAME_BITS_DEF   = 11;
    localparam int unsigned CLKS_PER_BIT_DEF = 5208;

    // Width needed to hold the frame down-counter, whose load value is frame_clks-1.
    function automatic int unsigned frame_cnt_w(input int unsigned clks_per_bit,
                                                input int unsigned frame_bits);
        int unsigned frame_clks;
        frame_clks = clks_per_bit * frame_bits;
        return (frame_clks > 1) ? $clog2(frame_clks) : 1;
    endfunction

endpackage

// File: rtl/uart_link_ctrl_if.sv
// Bundle of requester, UART-side and consumer-side signals of the UART link controller.
interface uart_link_ctrl_if;

    // Handshakes: a byte moves on any cycle where valid && ready are both high at the
    // rising edge; a source holds valid and data stable until that cycle.
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;

    logic [7:0] DataToTransmit;
    logic       Transmit;
    logic       RxInterrupt;
    logic [7:0] ReceivedData;
    logic       ParityError;
    logic       ClearInterrupt;

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_parity_err;
    logic       rx_ready;

    logic       tx_busy;
    logic       last_grant;
    logic       rx_overrun;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        input  RxInterrupt, ReceivedData, ParityError, rx_ready,
        output req0_ready, req1_ready, DataToTransmit, Transmit, ClearInterrupt,
        output rx_valid, rx_data, rx_parity_err, tx_busy, last_grant, rx_overrun
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        output RxInterrupt, ReceivedData, ParityError, rx_ready,
        input  req0_ready, req1_ready, DataToTransmit, Transmit, ClearInterrupt,
        input  rx_valid, rx_data, rx_parity_err, tx_busy, last_grant, rx_overrun
    );

endinterface

// File: rtl/uart_frame_timer.sv
// Down-counter that times one UART frame: load sets it to frame_clks-1, done when it reaches 0.
module uart_frame_timer
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned FRAME_BITS   = FRAME_BITS_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic count_i,
    output logic done_o
);

    localparam int unsigned CW = frame_cnt_w(CLKS_PER_BIT, FRAME_BITS);
    localparam logic [CW-1:0] LOAD_VAL = CW'(CLKS_PER_BIT * FRAME_BITS - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (count_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/uart_link_ctrl.sv
// UART link controller: round-robin arbitration of two byte requesters onto one UART
// transmitter, plus single-slot capture of received bytes with sticky overrun detection.
module uart_link_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned FRAME_BITS   = FRAME_BITS_DEF
) (
    input  logic            clk,
    input  logic            reset,
    uart_link_ctrl_if.slave lnk,
    output tx_state_e       tx_state_o
);

    tx_state_e  state_q, state_d;
    logic [7:0] dtx_q, dtx_d;
    logic       last_grant_q, last_grant_d;
    logic       grant_idx;
    logic       req0_rdy, req1_rdy, xfer;
    logic       tmr_load, tmr_count, tmr_done;

    // Both valid: the requester that did not win last time; otherwise the only valid one.
    always_comb begin
        grant_idx = lnk.req1_valid;
        if (lnk.req0_valid && lnk.req1_valid) begin
            grant_idx = ~last_grant_q;
        end
    end

    assign req0_rdy = (state_q == TX_IDLE) && lnk.req0_valid && !grant_idx;
    assign req1_rdy = (state_q == TX_IDLE) && lnk.req1_valid &&  grant_idx;
    assign xfer     = req0_rdy || req1_rdy;

    always_comb begin
        state_d      = state_q;
        dtx_d        = dtx_q;
        last_grant_d = last_grant_q;
        tmr_load     = 1'b0;
        tmr_count    = 1'b0;
        unique case (state_q)
            TX_IDLE: begin
                if (xfer) begin
                    state_d      = TX_SEND;
                    dtx_d        = grant_idx ? lnk.req1_data : lnk.req0_data;
                    last_grant_d = grant_idx;
                end
            end
            TX_SEND: begin
                tmr_load = 1'b1;
                state_d  = TX_WAIT;
            end
            TX_WAIT: begin
                if (tmr_done) begin
                    state_d = TX_IDLE;
                end else begin
                    tmr_count = 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= TX_IDLE;
            dtx_q        <= 8'h00;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            dtx_q        <= dtx_d;
            last_grant_q <= last_grant_d;
        end
    end

    uart_frame_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .FRAME_BITS   (FRAME_BITS)
    ) u_frame_timer (
        .clk     (clk),
        .reset   (reset),
        .load_i  (tmr_load),
        .count_i (tmr_count),
        .done_o  (tmr_done)
    );

    logic       irq_q;
    logic       clr_q, clr_d;
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_pe_q, rx_pe_d;
    logic       overrun_q, overrun_d;
    logic       rx_edge, rx_take, rx_capture;

    // The slot may be refilled in the same cycle the consumer empties it.
    always_comb begin
        rx_edge    = lnk.RxInterrupt && !irq_q;
        rx_take    = rx_valid_q && lnk.rx_ready;
        rx_capture = rx_edge && (!rx_valid_q || lnk.rx_ready);
        clr_d      = rx_edge;
        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;
        rx_pe_d    = rx_pe_q;
        overrun_d  = overrun_q;
        if (rx_capture) begin
            rx_valid_d = 1'b1;
            rx_data_d  = lnk.ReceivedData;
            rx_pe_d    = lnk.ParityError;
        end else if (rx_take) begin
            rx_valid_d = 1'b0;
        end
        if (rx_edge && !rx_capture) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q      <= 1'b0;
            clr_q      <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_pe_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            irq_q      <= lnk.RxInterrupt;
            clr_q      <= clr_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            rx_pe_q    <= rx_pe_d;
            overrun_q  <= overrun_d;
        end
    end

    assign lnk.req0_ready     = req0_rdy;
    assign lnk.req1_ready     = req1_rdy;
    assign lnk.DataToTransmit = dtx_q;
    assign lnk.Transmit       = (state_q == TX_SEND);
    assign lnk.tx_busy        = (state_q != TX_IDLE);
    assign lnk.last_grant     = last_grant_q;
    assign lnk.ClearInterrupt = clr_q;
    assign lnk.rx_valid       = rx_valid_q;
    assign lnk.rx_data        = rx_data_q;
    assign lnk.rx_parity_err  = rx_pe_q;
    assign lnk.rx_overrun     = overrun_q;
    assign tx_state_o         = state_q;

endmodule

// File: tb/tb_uart_link_ctrl.sv
// Bench for uart_link_ctrl: directed scenarios plus random traffic, all outputs checked
// every cycle against a frame-timing / single-slot reference model.
module tb_uart_link_ctrl;
    import uart_ctrl_pkg::*;

    localparam int CPB   = 4;
    localparam int FB    = 11;
    localparam int FRAME = CPB * FB;

    logic      clk   = 1'b0;
    logic      reset = 1'b1;
    tx_state_e tx_state;

    uart_link_ctrl_if lnk();

    uart_link_ctrl #(
        .CLKS_PER_BIT (CPB),
        .FRAME_BITS   (FB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .lnk        (lnk),
        .tx_state_o (tx_state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model state
    int         send_at = -1;
    int         free_at = 0;
    logic       m_lg    = 1'b1;
    logic [7:0] m_dtx   = 8'h00;
    logic [7:0] exp_q[$];
    logic [7:0] sent_q[$];
    int         busy_len = 0;
    int         clr_cnt  = 0;
    logic       m_prev = 1'b0, m_clr = 1'b0, m_rv = 1'b0, m_rpe = 1'b0, m_ovr = 1'b0;
    logic [7:0] m_rd = 8'h00;
    logic       e_r0, e_r1, m_idle, m_edge, v0, v1;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (!reset) begin
            check_eq("rst_transmit", lnk.Transmit, 1'b0);
            check_eq("rst_dtx", lnk.DataToTransmit, 8'h00);
            check_eq("rst_last_grant", lnk.last_grant, 1'b1);
            check_eq("rst_tx_busy", lnk.tx_busy, 1'b0);
            check_eq("rst_state", tx_state, TX_IDLE);
            check_eq("rst_clr", lnk.ClearInterrupt, 1'b0);
            check_eq("rst_rx_valid", lnk.rx_valid, 1'b0);
            check_eq("rst_rx_data", lnk.rx_data, 8'h00);
            check_eq("rst_rx_pe", lnk.rx_parity_err, 1'b0);
            check_eq("rst_overrun", lnk.rx_overrun, 1'b0);
            send_at = -1; free_at = 0; m_lg = 1'b1; m_dtx = 8'h00; exp_q.delete();
            busy_len = 0;
            m_prev = 1'b0; m_clr = 1'b0; m_rv = 1'b0; m_rpe = 1'b0; m_ovr = 1'b0; m_rd = 8'h00;
        end else begin
            // TX: one frame occupies the link from the cycle after acceptance for FRAME+1 cycles
            v0 = lnk.req0_valid;
            v1 = lnk.req1_valid;
            m_idle = (cyc >= free_at);
            if (!m_idle || !(v0 || v1)) begin
                e_r0 = 1'b0; e_r1 = 1'b0;
            end else if (v0 && v1) begin
                e_r0 = (m_lg == 1'b1); e_r1 = (m_lg == 1'b0);
            end else begin
                e_r0 = v0; e_r1 = v1;
            end
            check_eq("req0_ready", lnk.req0_ready, e_r0);
            check_eq("req1_ready", lnk.req1_ready, e_r1);
            check_eq("transmit", lnk.Transmit, (cyc == send_at));
            check_eq("tx_busy", lnk.tx_busy, (cyc >= send_at) && (cyc < free_at));
            check_eq("dtx_stable", lnk.DataToTransmit, m_dtx);
            check_eq("last_grant", lnk.last_grant, m_lg);
            if (cyc == send_at && exp_q.size() > 0) begin
                check_eq("tx_data", lnk.DataToTransmit, exp_q.pop_front());
            end
            if (lnk.Transmit) sent_q.push_back(lnk.DataToTransmit);
            if (lnk.tx_busy) begin
                busy_len++;
            end else if (busy_len > 0) begin
                check_eq("busy_len", busy_len, FRAME + 1);
                busy_len = 0;
            end
            if (e_r0 || e_r1) begin
                m_dtx = e_r1 ? lnk.req1_data : lnk.req0_data;
                exp_q.push_back(m_dtx);
                m_lg    = e_r1;
                send_at = cyc + 1;
                free_at = cyc + 2 + FRAME;
            end

            // RX: one-entry slot fed by rising edges of RxInterrupt
            check_eq("clear_irq", lnk.ClearInterrupt, m_clr);
            check_eq("rx_valid", lnk.rx_valid, m_rv);
            check_eq("rx_data", lnk.rx_data, m_rd);
            check_eq("rx_parity_err", lnk.rx_parity_err, m_rpe);
            check_eq("rx_overrun", lnk.rx_overrun, m_ovr);
            if (lnk.ClearInterrupt) clr_cnt++;
            m_edge = lnk.RxInterrupt && !m_prev;
            m_prev = lnk.RxInterrupt;
            m_clr  = m_edge;
            if (m_edge && m_rv && !lnk.rx_ready) begin
                m_ovr = 1'b1;
            end else if (m_edge) begin
                m_rv = 1'b1; m_rd = lnk.ReceivedData; m_rpe = lnk.ParityError;
            end else if (m_rv && lnk.rx_ready) begin
                m_rv = 1'b0;
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic send_req(input int idx, input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        if (idx == 0) begin lnk.req0_valid = 1'b1; lnk.req0_data = d; end
        else          begin lnk.req1_valid = 1'b1; lnk.req1_data = d; end
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = (idx == 0) ? lnk.req0_ready : lnk.req1_ready;
            tick();
        end
        if (idx == 0) lnk.req0_valid = 1'b0; else lnk.req1_valid = 1'b0;
        check_eq("handshake_done", ok, 1'b1);
    endtask

    task automatic rx_event(input logic [7:0] d, input logic pe, input int hold, input logic rdy);
        lnk.RxInterrupt  = 1'b1;
        lnk.ReceivedData = d;
        lnk.ParityError  = pe;
        lnk.rx_ready     = rdy;
        tick();
        lnk.rx_ready = 1'b0;
        wait_cycles(hold - 1);
        lnk.RxInterrupt = 1'b0;
    endtask

    int         base;
    int         clr0;
    logic       acc0, acc1;
    logic [7:0] rr_exp [4];

    initial begin
        lnk.req0_valid = 1'b0; lnk.req0_data = 8'h00;
        lnk.req1_valid = 1'b0; lnk.req1_data = 8'h00;
        lnk.RxInterrupt = 1'b0; lnk.ReceivedData = 8'h00; lnk.ParityError = 1'b0;
        lnk.rx_ready = 1'b0;
        #1 reset = 1'b0;
        wait_cycles(3);
        reset = 1'b1;
        wait_cycles(2);

        // Single requester frame
        base = sent_q.size();
        send_req(0, 8'hA5);
        wait_cycles(FRAME + 5);
        check_eq("a5_frames", sent_q.size() - base, 1);
        if (sent_q.size() > base) check_eq("a5_byte", sent_q[base], 8'hA5);

        // Both requesters held from reset: strict alternation starting with requester 0
        reset = 1'b0;
        lnk.req0_valid = 1'b1; lnk.req0_data = 8'h11;
        lnk.req1_valid = 1'b1; lnk.req1_data = 8'h22;
        wait_cycles(2);
        base = sent_q.size();
        reset = 1'b1;
        wait_cycles(4 * (FRAME + 2) - 10);
        lnk.req0_valid = 1'b0; lnk.req1_valid = 1'b0;
        wait_cycles(FRAME + 5);
        rr_exp[0] = 8'h11; rr_exp[1] = 8'h22; rr_exp[2] = 8'h11; rr_exp[3] = 8'h22;
        check_eq("rr_frames", sent_q.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            if (sent_q.size() > base + i) check_eq("rr_order", sent_q[base + i], rr_exp[i]);
        end

        // RX capture, held level, overrun
        clr0 = clr_cnt;
        rx_event(8'h5A, 1'b1, 3, 1'b0);
        wait_cycles(2);
        check_eq("rx1_clr_pulses", clr_cnt - clr0, 1);
        check_eq("rx1_valid", lnk.rx_valid, 1'b1);
        check_eq("rx1_data", lnk.rx_data, 8'h5A);
        check_eq("rx1_pe", lnk.rx_parity_err, 1'b1);
        clr0 = clr_cnt;
        rx_event(8'h33, 1'b0, 2, 1'b0);
        wait_cycles(2);
        check_eq("ovr_clr_pulses", clr_cnt - clr0, 1);
        check_eq("ovr_data_kept", lnk.rx_data, 8'h5A);
        check_eq("ovr_flag", lnk.rx_overrun, 1'b1);
        wait_cycles(3);
        check_eq("ovr_sticky", lnk.rx_overrun, 1'b1);

        // Refill in the same cycle as consumption
        reset = 1'b0;
        wait_cycles(2);
        reset = 1'b1;
        rx_event(8'h5A, 1'b1, 2, 1'b0);
        wait_cycles(2);
        rx_event(8'h77, 1'b0, 2, 1'b1);
        wait_cycles(2);
        check_eq("refill_valid", lnk.rx_valid, 1'b1);
        check_eq("refill_data", lnk.rx_data, 8'h77);
        check_eq("refill_no_ovr", lnk.rx_overrun, 1'b0);
        lnk.rx_ready = 1'b1;
        tick();
        lnk.rx_ready = 1'b0;
        check_eq("rx_consumed", lnk.rx_valid, 1'b0);

        // Reset in the middle of a frame, then requester 1 waiting across release
        send_req(0, 8'hC3);
        wait_cycles(21);
        reset = 1'b0;
        tick();
        check_eq("abort_transmit", lnk.Transmit, 1'b0);
        check_eq("abort_busy", lnk.tx_busy, 1'b0);
        check_eq("abort_dtx", lnk.DataToTransmit, 8'h00);
        lnk.req1_valid = 1'b1; lnk.req1_data = 8'h3C;
        wait_cycles(2);
        base = sent_q.size();
        reset = 1'b1;
        send_req(1, 8'h3C);
        wait_cycles(FRAME + 5);
        check_eq("post_rst_frames", sent_q.size() - base, 1);
        if (sent_q.size() > base) check_eq("post_rst_byte", sent_q[base], 8'h3C);
        check_eq("post_rst_grant", lnk.last_grant, 1'b1);

        // Random concurrent TX and RX traffic with one reset in the middle
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc0 = lnk.req0_valid && lnk.req0_ready;
            acc1 = lnk.req1_valid && lnk.req1_ready;
            tick();
            if (acc0 || !lnk.req0_valid) begin
                lnk.req0_valid = ($urandom_range(0, 3) == 0);
                lnk.req0_data  = 8'($urandom_range(0, 255));
            end
            if (acc1 || !lnk.req1_valid) begin
                lnk.req1_valid = ($urandom_range(0, 3) == 0);
                lnk.req1_data  = 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 4) == 0) lnk.RxInterrupt = ~lnk.RxInterrupt;
            lnk.ReceivedData = 8'($urandom_range(0, 255));
            lnk.ParityError  = ($urandom_range(0, 1) == 1);
            lnk.rx_ready     = ($urandom_range(0, 3) == 0);
            if (c == 1500) reset = 1'b0;
            if (c == 1503) reset = 1'b1;
        end

        lnk.req0_valid = 1'b0; lnk.req1_valid = 1'b0;
        lnk.RxInterrupt = 1'b0; lnk.rx_ready = 1'b0;
        wait_cycles(FRAME + 5);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got cycle %0d expected finish before limit", cyc);
        $fatal(1);
    end

endmodule
